// File: rtl/dec_pulse_if.sv
// Handshake and output bundle for the dec_pulse timed 3-to-8 decoder.
// The master side drives codes and control; the slave side is the decoder.
interface dec_pulse_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             in_valid;
  logic [2:0]       in_code;
  logic             in_ready;
  logic [7:0]       y;
  logic             y_valid;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output en, clr, in_valid, in_code,
    input  in_ready, y, y_valid, busy, done_cnt
  );

  modport slave (
    input  en, clr, in_valid, in_code,
    output in_ready, y, y_valid, busy, done_cnt
  );
endinterface

// File: rtl/dec_pulse.sv
// Registered 3-to-8 decoder: each accepted code becomes a one-hot pulse held for
// HOLD_CYCLES clocks, followed by GAP_CYCLES clocks of all-zero output.
module dec_pulse #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 1,
  parameter int unsigned CNT_W       = 8
) (
  input logic        clk,
  input logic        rst_n,
  dec_pulse_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

  // Timer counts down to zero, so a load of N-1 yields exactly N clocks in the state.
  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GapLoad  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_e           state_q;
  logic [2:0]       code_q;
  logic [7:0]       timer_q;
  logic [7:0]       y_q;
  logic             y_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] done_cnt_q;

  logic in_ready;
  logic xfer;

  assign in_ready = (state_q == StIdle) & bus.en & ~bus.clr;
  assign xfer     = bus.in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      code_q     <= '0;
      timer_q    <= '0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_cnt_q <= '0;
    end else if (bus.clr) begin
      // Abort from any state; an interrupted pulse is not counted as done.
      state_q   <= StIdle;
      timer_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            code_q    <= bus.in_code;
            timer_q   <= HoldLoad;
            state_q   <= StHold;
            y_q       <= 8'd1 << bus.in_code;
            y_valid_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StHold: begin
          if (timer_q != 8'd0) begin
            timer_q <= timer_q - 8'd1;
            y_q     <= 8'd1 << code_q;
          end else begin
            done_cnt_q <= done_cnt_q + 1'b1;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state_q <= StGap;
              timer_q <= GapLoad;
            end else begin
              state_q <= StIdle;
              timer_q <= '0;
              busy_q  <= 1'b0;
            end
          end
        end
        StGap: begin
          if (timer_q != 8'd0) begin
            timer_q <= timer_q - 8'd1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          timer_q   <= '0;
          y_q       <= '0;
          y_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.y        = y_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done_cnt = done_cnt_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ((y_q & (y_q - 8'd1)) == 8'd0)
        else $error("dec_pulse: y is multi-hot");
    end
  end

endmodule

// File: tb/tb_dec_pulse.sv
// Random and directed stimulus on two decoder configurations, each checked against
// a remaining-cycles reference model.
module tb_dec_pulse;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec_pulse_if #(.CNT_W(8)) bus_a ();
  dec_pulse_if #(.CNT_W(2)) bus_b ();

  dec_pulse #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  dec_pulse #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(2)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // Model tracks how many pulse and gap clocks remain; idle when both are zero.
  typedef struct {
    int hold_left;
    int gap_left;
    int code;
    int done;
  } mdl_t;

  mdl_t ma, mb;
  int   vectors = 0;
  int   errors  = 0;

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.hold_left = 0;
    m.gap_left  = 0;
    m.code      = 0;
    m.done      = 0;
    return m;
  endfunction

  function automatic bit mdl_ready(mdl_t m, bit en, bit clr);
    return (m.hold_left == 0) && (m.gap_left == 0) && en && !clr;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int hold, int gap, int cntw,
                                    bit en, bit clr, bit valid, int code);
    mdl_t n = m;
    if (clr) begin
      n.hold_left = 0;
      n.gap_left  = 0;
    end else if (mdl_ready(m, en, clr) && valid) begin
      n.code      = code;
      n.hold_left = hold;
      n.gap_left  = gap;
    end else if (m.hold_left > 0) begin
      n.hold_left = m.hold_left - 1;
      if (n.hold_left == 0) n.done = (m.done + 1) % (1 << cntw);
    end else if (m.gap_left > 0) begin
      n.gap_left = m.gap_left - 1;
    end
    return n;
  endfunction

  function automatic int mdl_y(mdl_t m);
    return (m.hold_left > 0) ? (1 << m.code) : 0;
  endfunction

  function automatic int mdl_busy(mdl_t m);
    return ((m.hold_left > 0) || (m.gap_left > 0)) ? 1 : 0;
  endfunction

  task automatic check_outputs();
    check_eq("a.y",        32'(bus_a.y),        32'(mdl_y(ma)));
    check_eq("a.y_valid",  32'(bus_a.y_valid),  32'(mdl_y(ma) != 0));
    check_eq("a.busy",     32'(bus_a.busy),     32'(mdl_busy(ma)));
    check_eq("a.done_cnt", 32'(bus_a.done_cnt), 32'(ma.done));
    check_eq("a.onehot",   32'($countones(bus_a.y) <= 1), 32'd1);
    check_eq("b.y",        32'(bus_b.y),        32'(mdl_y(mb)));
    check_eq("b.y_valid",  32'(bus_b.y_valid),  32'(mdl_y(mb) != 0));
    check_eq("b.busy",     32'(bus_b.busy),     32'(mdl_busy(mb)));
    check_eq("b.done_cnt", 32'(bus_b.done_cnt), 32'(mb.done));
  endtask

  task automatic drive(bit en, bit clr, bit valid, logic [2:0] code);
    bus_a.en = en;  bus_a.clr = clr;  bus_a.in_valid = valid;  bus_a.in_code = code;
    bus_b.en = en;  bus_b.clr = clr;  bus_b.in_valid = valid;  bus_b.in_code = code;
  endtask

  // One clock: drive at negedge, check in_ready, then check registered outputs after the edge.
  task automatic cycle(bit en, bit clr, bit valid, logic [2:0] code);
    @(negedge clk);
    drive(en, clr, valid, code);
    #1;
    check_eq("a.in_ready", 32'(bus_a.in_ready), 32'(mdl_ready(ma, en, clr)));
    check_eq("b.in_ready", 32'(bus_b.in_ready), 32'(mdl_ready(mb, en, clr)));
    @(posedge clk);
    ma = mdl_step(ma, 4, 1, 8, en, clr, valid, int'(code));
    mb = mdl_step(mb, 1, 0, 2, en, clr, valid, int'(code));
    #1;
    check_outputs();
  endtask

  initial begin
    ma = mdl_reset();
    mb = mdl_reset();
    drive(1'b0, 1'b0, 1'b0, 3'd0);
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single code 5: four clocks of pulse, one gap clock, then ready again.
    cycle(1'b1, 1'b0, 1'b1, 3'd5);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 3'd0);

    // Sweep all codes with valid held high; each code waits for its accept.
    for (int c = 0; c < 8; c++) begin
      bit acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        acc = mdl_ready(ma, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 3'(c));
      end
      check_eq("sweep.accept", 32'(acc), 32'd1);
    end
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 3'd0);

    // Abort code 3 on its second pulse clock, then accept a new code.
    cycle(1'b1, 1'b0, 1'b1, 3'd3);
    cycle(1'b1, 1'b0, 1'b0, 3'd0);
    cycle(1'b1, 1'b1, 1'b1, 3'd1);
    cycle(1'b1, 1'b0, 1'b1, 3'd6);
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 3'd0);

    // en low blocks new codes but does not cut short a running pulse.
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 3'd7);
    cycle(1'b1, 1'b0, 1'b1, 3'd4);
    repeat (7) cycle(1'b0, 1'b0, 1'b1, 3'd2);

    // Asynchronous reset in the middle of a pulse.
    cycle(1'b1, 1'b0, 1'b1, 3'd2);
    cycle(1'b1, 1'b0, 1'b0, 3'd0);
    #2;
    rst_n = 1'b0;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    check_outputs();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;

    // Five back-to-back pulses on the narrow-counter instance wrap its count.
    repeat (10) cycle(1'b1, 1'b0, 1'b1, 3'($urandom_range(0, 7)));
    check_eq("b.wrap", 32'(bus_b.done_cnt), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
